// File: rtl/bsort_pkg.sv
// Shared types and constants for the bubble-sort register-file unload path.
// Defining BSORT_UNLOAD_DESCEND_EN streams from the last address down to 0.
package bsort_pkg;

    localparam int BSORT_WIDTH = 8;
    localparam int BSORT_DEPTH = 8;
    localparam int BSORT_AW    = 3;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        FIN
    } unload_state_t;

`ifdef BSORT_UNLOAD_DESCEND_EN
    localparam bit BSORT_DESCEND = 1'b1;
`else
    localparam bit BSORT_DESCEND = 1'b0;
`endif

    // Address walk endpoints for a file of the given depth.
    function automatic int unsigned first_addr(input int unsigned depth);
        return BSORT_DESCEND ? depth - 32'd1 : 32'd0;
    endfunction

    function automatic int unsigned final_addr(input int unsigned depth);
        return BSORT_DESCEND ? 32'd0 : depth - 32'd1;
    endfunction

endpackage

// File: rtl/bsort_unload_if.sv
// Register-file read port plus valid/ready byte stream of the unload sequencer.
// master = the sequencer, slave = register file / downstream consumer side.
interface bsort_unload_if
    import bsort_pkg::*;
#(
    parameter int WIDTH = BSORT_WIDTH,
    parameter int AW    = BSORT_AW
);
    logic             start;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_last;
    logic             busy;
    logic             done;

    modport master (
        input  start, rd_data, dout_ready,
        output rd_en, rd_addr, dout, dout_valid, dout_last, busy, done
    );

    modport slave (
        output start, rd_data, dout_ready,
        input  rd_en, rd_addr, dout, dout_valid, dout_last, busy, done
    );
endinterface

// File: rtl/bsort_unload.sv
// Walks the sorted register file and streams one byte per FETCH/SEND pair.
// Build option: BSORT_UNLOAD_DESCEND_EN reverses the walk (largest-first).
module bsort_unload
    import bsort_pkg::*;
#(
    parameter int WIDTH = BSORT_WIDTH,
    parameter int DEPTH = BSORT_DEPTH,
    parameter int AW    = BSORT_AW
) (
    input  logic           clk,
    input  logic           reset_j,
    bsort_unload_if.master bus
);
    localparam logic [AW-1:0] FIRST_ADDR = AW'(first_addr(DEPTH));
    localparam logic [AW-1:0] FINAL_ADDR = AW'(final_addr(DEPTH));

    unload_state_t    state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             rd_en_q, rd_en_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q, dout_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic handshake;
    assign handshake = dout_valid_q & bus.dout_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset_j) begin
        if (reset_j) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = FETCH;
            FETCH:   state_d = SEND;
            SEND:    if (handshake) state_d = dout_last_q ? FIN : FETCH;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every output is given a hold/default value first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        ptr_d        = ptr_q;
        rd_en_d      = rd_en_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        done_d       = 1'b0;
        busy_d       = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ptr_d   = FIRST_ADDR;
                    rd_en_d = 1'b1;
                end
            end
            FETCH: begin
                dout_d       = bus.rd_data;
                dout_valid_d = 1'b1;
                dout_last_d  = (ptr_q == FINAL_ADDR);
            end
            SEND: begin
                if (handshake) begin
                    dout_valid_d = 1'b0;
                    if (dout_last_q) begin
                        rd_en_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = BSORT_DESCEND ? ptr_q - AW'(1) : ptr_q + AW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset_j) begin
        if (reset_j) begin
            ptr_q        <= '0;
            rd_en_q      <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            rd_en_q      <= rd_en_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // The enclosing top muxes rd_addr onto the register file while rd_en is high.
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = ptr_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_last  = dout_last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_bsort_unload.sv
// Randomized bench for bsort_unload with a queue-based model of the expected stream.
// Define BSORT_UNLOAD_DESCEND_EN for both RTL and bench to check the descending build.
`timescale 1ns/1ps
module tb_bsort_unload;
    import bsort_pkg::*;

    localparam int W = BSORT_WIDTH;
    localparam int D = BSORT_DEPTH;
    localparam int A = BSORT_AW;

    logic clk = 1'b0;
    logic reset_j;
    always #5 clk = ~clk;

    bsort_unload_if #(.WIDTH(W), .AW(A)) bus ();

    logic [W-1:0] regfile [D];
    assign bus.rd_data = regfile[bus.rd_addr];

    bsort_unload #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
        .clk     (clk),
        .reset_j (reset_j),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [$];

    // Model: the stream is the file contents in address order (or reversed).
    function automatic void build_expect();
        exp_q.delete();
        for (int i = 0; i < D; i++) begin
`ifdef BSORT_UNLOAD_DESCEND_EN
            exp_q.push_back(regfile[D-1-i]);
`else
            exp_q.push_back(regfile[i]);
`endif
        end
    endfunction

    task automatic load_demo_file();
        regfile[0] = 8'd3; regfile[1] = 8'd1; regfile[2] = 8'd4; regfile[3] = 8'd1;
        regfile[4] = 8'd5; regfile[5] = 8'd9; regfile[6] = 8'd2; regfile[7] = 8'd6;
    endtask

    task automatic check_all_zero(input string tag);
        logic [W+A+6-1:0] got;
        got = {bus.rd_en, bus.rd_addr, bus.dout, bus.dout_valid, bus.dout_last, bus.busy, bus.done};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s: outputs {rd_en,rd_addr,dout,valid,last,busy,done}=%h, expected all zero", tag, got);
        end
    endtask

    // One start, then per-cycle observation at the falling edge until done drops.
    task automatic run_stream(input string tag, input bit rand_ready, input int stall_idx,
                              input int stall_len, input int poke_start_idx,
                              input int poke_data_idx, input int abort_idx, output bit aborted);
        int got = 0, dones = 0, stall_left = stall_len, first_valid = -1, done_cyc = -1;
        bit held = 1'b0, finished = 1'b0;
        logic [W-1:0] held_dout;
        logic held_last;
        aborted = 1'b0;
        build_expect();
        @(negedge clk);
        bus.start = 1'b1;
        bus.dout_ready = 1'b0;
        for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (held) begin
                checks++;
                if (bus.dout_valid !== 1'b1 || bus.dout !== held_dout || bus.dout_last !== held_last) begin
                    errors++;
                    $display("FAIL %s hold: valid=%b dout=%0d last=%b, expected valid=1 dout=%0d last=%b",
                             tag, bus.dout_valid, bus.dout, bus.dout_last, held_dout, held_last);
                end
            end
            held = 1'b0;
            if (dones > 0 && bus.done !== 1'b1) begin
                checks++;
                if (bus.busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s after_done: busy=%b valid=%b, expected 0 0", tag, bus.busy, bus.dout_valid);
                end
                finished = 1'b1;
            end
            if (bus.done === 1'b1) begin
                dones++;
                done_cyc = cyc;
            end
            if (bus.dout_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (bus.dout_valid === 1'b1 && got == abort_idx) begin
                aborted = 1'b1;
                return;
            end
            if (bus.dout_valid === 1'b1 && got == poke_start_idx) bus.start = 1'b1;
            if (bus.dout_valid === 1'b1 && got == poke_data_idx && stall_left > 0)
                regfile[bus.rd_addr] = ~regfile[bus.rd_addr];
            if (bus.dout_valid === 1'b1 && got == stall_idx && stall_left > 0) begin
                bus.dout_ready = 1'b0;
                stall_left--;
            end else begin
                bus.dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (bus.dout_valid === 1'b1 && bus.dout_ready) begin
                checks++;
                if (got >= D) begin
                    errors++;
                    $display("FAIL %s extra_byte: dout=%0d beyond %0d bytes", tag, bus.dout, D);
                end else begin
                    if (bus.dout !== exp_q[got] || bus.dout_last !== (got == D-1)) begin
                        errors++;
                        $display("FAIL %s byte%0d: dout=%0d last=%b, expected dout=%0d last=%b",
                                 tag, got, bus.dout, bus.dout_last, exp_q[got], (got == D-1));
                    end
                end
                got++;
            end else if (bus.dout_valid === 1'b1) begin
                held = 1'b1;
                held_dout = bus.dout;
                held_last = bus.dout_last;
            end
        end
        bus.dout_ready = 1'b0;
        checks++;
        if (!finished || got != D || dones != 1 || first_valid != 2) begin
            errors++;
            $display("FAIL %s summary: finished=%b bytes=%0d dones=%0d first_valid_cycle=%0d, expected 1 %0d 1 2",
                     tag, finished, got, dones, first_valid, D);
        end
        if (!rand_ready) begin
            checks++;
            if (done_cyc != 2*D + 1 + stall_len) begin
                errors++;
                $display("FAIL %s done_cycle: got %0d, expected %0d", tag, done_cyc, 2*D + 1 + stall_len);
            end
        end
    endtask

    task automatic test_reset();
        bit ab;
        reset_j = 1'b1;
        bus.start = 1'b0;
        bus.dout_ready = 1'b0;
        load_demo_file();
        #1;
        check_all_zero("reset_async");
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        reset_j = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_basic_stream();
        bit ab;
        load_demo_file();
        run_stream("basic", 1'b0, -1, 0, -1, -1, -1, ab);
    endtask

    task automatic test_backpressure();
        bit ab;
        load_demo_file();
        run_stream("backpressure", 1'b0, 1, 5, -1, -1, -1, ab);
    endtask

    task automatic test_start_while_busy();
        bit ab;
        load_demo_file();
        run_stream("start_busy", 1'b0, -1, 0, 2, -1, -1, ab);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.dout_valid !== 1'b0 || bus.rd_en !== 1'b0) begin
            errors++;
            $display("FAIL start_busy queued: busy=%b valid=%b rd_en=%b, expected 0 0 0",
                     bus.busy, bus.dout_valid, bus.rd_en);
        end
    endtask

    task automatic test_reset_mid_stream();
        bit ab;
        load_demo_file();
        run_stream("mid_reset_a", 1'b0, -1, 0, -1, -1, 4, ab);
        checks++;
        if (ab !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset reach_byte5: aborted=%b, expected 1", ab);
        end
        #2 reset_j = 1'b1;
        #1 check_all_zero("mid_reset_async");
        @(negedge clk);
        check_all_zero("mid_reset_held");
        reset_j = 1'b0;
        run_stream("mid_reset_b", 1'b0, -1, 0, -1, -1, -1, ab);
    endtask

    task automatic test_rd_data_change();
        bit ab;
        load_demo_file();
        run_stream("rd_data_change", 1'b0, 3, 3, -1, 3, -1, ab);
        load_demo_file();
    endtask

    task automatic test_random();
        bit ab;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < D; i++) regfile[i] = W'($urandom);
            run_stream("random", 1'b1, -1, 0, -1, -1, -1, ab);
        end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_stream();
        test_rd_data_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
